// File: rtl/cv32e40p_tmr_fault_manager_if.sv
// Voter/supervisor bundle for the TMR fault manager.
// master drives votes and acks; slave is the fault manager.
interface cv32e40p_tmr_fault_manager_if #(
    parameter int CNT_W = 8
);
    logic               vote_valid_i;
    logic               err_detected_1_i;
    logic               err_detected_2_i;
    logic               err_detected_3_i;
    logic               err_corrected_i;
    logic               resync_ack_i;
    logic               resync_req_o;
    logic [1:0]         resync_id_o;
    logic [2:0]         replica_mask_o;
    logic               degraded_o;
    logic               fatal_o;
    logic [3*CNT_W-1:0] err_cnt_o;

    modport master (
        output vote_valid_i,
        output err_detected_1_i,
        output err_detected_2_i,
        output err_detected_3_i,
        output err_corrected_i,
        output resync_ack_i,
        input  resync_req_o,
        input  resync_id_o,
        input  replica_mask_o,
        input  degraded_o,
        input  fatal_o,
        input  err_cnt_o
    );

    modport slave (
        input  vote_valid_i,
        input  err_detected_1_i,
        input  err_detected_2_i,
        input  err_detected_3_i,
        input  err_corrected_i,
        input  resync_ack_i,
        output resync_req_o,
        output resync_id_o,
        output replica_mask_o,
        output degraded_o,
        output fatal_o,
        output err_cnt_o
    );
endinterface

// File: rtl/cv32e40p_tmr_fault_manager.sv
// TMR fault manager: leaky per-replica error counters,
// resync requests, permanent masking and sticky fatal.
module cv32e40p_tmr_fault_manager #(
    parameter int CNT_W          = 8,
    parameter int THRESH         = 4,
    parameter int WINDOW         = 1024,
    parameter int MAX_RESYNC     = 2,
    parameter int RESYNC_TIMEOUT = 64
) (
    input logic clk_i,
    input logic rst_i,
    cv32e40p_tmr_fault_manager_if.slave bus
);

    localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int AW = (MAX_RESYNC > 0) ? $clog2(MAX_RESYNC + 1) : 1;
    localparam int TW = $clog2(RESYNC_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_RUN,
        S_RESYNC,
        S_FATAL
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];
    logic [AW-1:0]    att_q [3];
    logic [AW-1:0]    att_d [3];
    logic [WW-1:0]    win_q, win_d;
    logic [TW-1:0]    to_q, to_d;
    logic [2:0]       mask_q, mask_d;
    logic [1:0]       id_q, id_d;

    logic [CNT_W-1:0] cnt_new [3];
    logic [2:0]       err, marked, sel, retry, id_oh;
    logic [1:0]       sel_id;
    logic             sample, leak, any_masked;

    assign err        = {bus.err_detected_3_i, bus.err_detected_2_i,
                         bus.err_detected_1_i} & ~mask_q;
    assign sample     = (state_q == S_RUN) && bus.vote_valid_i;
    assign leak       = sample && (win_q == WW'(WINDOW - 1));
    assign any_masked = |mask_q;

    // Leaky saturating counter update for the current sample.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            cnt_new[k] = cnt_q[k];
            if (sample) begin
                if (err[k] && !leak) begin
                    if (cnt_q[k] != CNT_MAX) begin
                        cnt_new[k] = cnt_q[k] + CNT_W'(1);
                    end
                end else if (!err[k] && leak && cnt_q[k] != '0) begin
                    cnt_new[k] = cnt_q[k] - CNT_W'(1);
                end
            end
        end
    end

    // Threshold detection, lowest-index pick and retry budget.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            marked[k] = !mask_q[k] && (cnt_new[k] >= CNT_W'(THRESH));
            retry[k]  = att_q[k] < AW'(MAX_RESYNC);
            id_oh[k]  = (id_q == 2'(k));
        end
        sel    = marked & (~marked + 3'd1);
        sel_id = sel[0] ? 2'd0 : (sel[1] ? 2'd1 : 2'd2);
    end

    // Next-state logic for the supervisor FSM and its counters.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        att_d   = att_q;
        win_d   = win_q;
        to_d    = to_q;
        mask_d  = mask_q;
        id_d    = id_q;
        unique case (state_q)
            S_RUN: begin
                if (sample && |err &&
                    (any_masked || !bus.err_corrected_i)) begin
                    state_d = S_FATAL;
                end else if (|sel && !(|(sel & retry)) && any_masked) begin
                    // a second replica would have to be dropped
                    state_d = S_FATAL;
                end else begin
                    cnt_d = cnt_new;
                    if (sample) begin
                        win_d = leak ? '0 : win_q + WW'(1);
                    end
                    if (|(sel & retry)) begin
                        state_d = S_RESYNC;
                        id_d    = sel_id;
                        to_d    = '0;
                    end else if (|sel) begin
                        mask_d = mask_q | sel;
                        for (int k = 0; k < 3; k++) begin
                            if (sel[k]) cnt_d[k] = '0;
                        end
                    end
                end
            end
            S_RESYNC: begin
                if (bus.resync_ack_i) begin
                    state_d = S_RUN;
                    to_d    = '0;
                    for (int k = 0; k < 3; k++) begin
                        if (id_oh[k]) begin
                            cnt_d[k] = '0;
                            att_d[k] = att_q[k] + AW'(1);
                        end
                    end
                end else if (to_q == TW'(RESYNC_TIMEOUT - 1)) begin
                    to_d = '0;
                    if (any_masked) begin
                        state_d = S_FATAL;
                    end else begin
                        state_d = S_RUN;
                        mask_d  = mask_q | id_oh;
                    end
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            S_FATAL: begin
                state_d = S_FATAL;
            end
            default: begin
                state_d = S_FATAL;
            end
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_RUN;
            cnt_q   <= '{default: '0};
            att_q   <= '{default: '0};
            win_q   <= '0;
            to_q    <= '0;
            mask_q  <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            att_q   <= att_d;
            win_q   <= win_d;
            to_q    <= to_d;
            mask_q  <= mask_d;
            id_q    <= id_d;
        end
    end

    assign bus.resync_req_o   = (state_q == S_RESYNC);
    assign bus.resync_id_o    = (state_q == S_RESYNC) ? id_q : 2'd0;
    assign bus.replica_mask_o = mask_q;
    assign bus.degraded_o     = any_masked;
    assign bus.fatal_o        = (state_q == S_FATAL);

    for (genvar g = 0; g < 3; g++) begin : g_cnt
        assign bus.err_cnt_o[g*CNT_W +: CNT_W] = cnt_q[g];
    end

endmodule
